// File: rtl/mc_ctrl_pkg.sv
// Shared control-path definitions for the handshaking multicycle MIPS controller:
// state encoding, mux select codes, ALU/opcode encodings and the ALU op decode.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, ADDR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, EXI, WBI, JUMP, HALT
  } state_t;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  function automatic logic is_shift(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

  function automatic logic is_rtype_alu(input logic [5:0] funct);
    logic ok;
    case (funct)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] aluop_decode(input logic [5:0] opcode, input logic [5:0] funct);
    logic [3:0] op;
    op = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SLL:           op = ALU_SLL;
        FN_SRL:           op = ALU_SRL;
        FN_SRA:           op = ALU_SRA;
        FN_SUB, FN_SUBU:  op = ALU_SUB;
        FN_AND:           op = ALU_AND;
        FN_OR:            op = ALU_OR;
        FN_XOR:           op = ALU_XOR;
        FN_NOR:           op = ALU_NOR;
        FN_SLT:           op = ALU_SLT;
        FN_SLTU:          op = ALU_SLTU;
        default:          op = ALU_ADD;
      endcase
    end else begin
      case (opcode)
        OP_ANDI: op = ALU_AND;
        OP_ORI:  op = ALU_OR;
        OP_XORI: op = ALU_XOR;
        OP_SLTI: op = ALU_SLT;
        default: op = ALU_ADD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mc_control_hs_watchdog.sv
// Memory handshake watchdog: counts advancing wait cycles of an outstanding request
// and raises a sticky error when MEM_TIMEOUT cycles pass without mem_ready.
module mc_mem_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic adv_i,
  input  logic wait_i,
  output logic timeout_o,
  output logic mem_err_o
);
  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  assign timeout_o = adv_i & wait_i & (cnt_q == LAST_WAIT);
  assign mem_err_o = err_q;

  // A request leaves its state only on mem_ready or timeout, so clearing
  // whenever no wait is pending also covers every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) cnt_d = (wait_i && !timeout_o) ? cnt_q + CW'(1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (timeout_o) err_q <= 1'b1;
    end
  end
endmodule

// File: rtl/mc_control_hs.sv
// Multicycle MIPS control FSM with variable-latency memory handshake, watchdog and
// retire counter. Define ILLEGAL_TRAP_EN to halt on unknown instructions (adds trap).
module mc_control_hs
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             stall,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             IorD,
  output logic             ALUSrcA,
  output logic             MemToReg,
  output logic             RegDst,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUControl,
  output logic             ExtOp,
  output logic             UseShamt,
  output logic             WriteRA,
  output logic             BranchEQ,
  output logic             BranchNE,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_dbg
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             trap
`endif
);
`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = HALT;
`else
  localparam state_t ILLEGAL_NEXT = FETCH;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             advance, timeout;

  assign advance     = clk_en & ~stall;
  assign instr_count = count_q;
  assign state_dbg   = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign trap = (state_q == HALT);
`endif

  mc_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .adv_i     (advance),
    .wait_i    (mem_req & ~mem_ready),
    .timeout_o (timeout),
    .mem_err_o (mem_err)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_JR)           state_d = JUMP;
            else if (is_rtype_alu(funct)) state_d = EXEC;
            else                          state_d = ILLEGAL_NEXT;
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = EXI;
          OP_LW, OP_SW:   state_d = ADDR;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J, OP_JAL:   state_d = JUMP;
          default:        state_d = ILLEGAL_NEXT;
        endcase
      end
      ADDR:   state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = WBI;
      MEMWR:  if (mem_ready) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      EXI:    state_d = WBI;
      ALUWB, WBI, BRANCH, JUMP: state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
    // An abandoned request restarts the fetch without retiring anything.
    if (timeout) state_d = FETCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      count_q <= '0;
    end else if (advance) begin
      state_q <= state_d;
      if (state_d == FETCH && state_q != FETCH && !timeout) count_q <= count_q + CNT_W'(1);
    end
  end

  // Strobes are forced idle while rst is high so a pending request drops at once.
  always_comb begin
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    MemToReg   = 1'b0;
    RegDst     = 1'b0;
    PCSrc      = PCSRC_ALU;
    ALUSrcB    = SRCB_REG;
    ALUControl = ALU_ADD;
    ExtOp      = 1'b1;
    UseShamt   = 1'b0;
    WriteRA    = 1'b0;
    BranchEQ   = 1'b0;
    BranchNE   = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready & advance;
          PCWrite = mem_ready & advance;
        end
        DECODE: ALUSrcB = SRCB_IMM_SH2;
        ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MEMRD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        MEMWR: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        EXEC: begin
          ALUSrcA    = 1'b1;
          ALUControl = aluop_decode(opcode, funct);
          UseShamt   = is_shift(funct);
        end
        ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        EXI: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          ALUControl = aluop_decode(opcode, funct);
          ExtOp      = !((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI));
        end
        WBI: begin
          RegWrite = 1'b1;
          MemToReg = (opcode == OP_LW);
        end
        BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUControl = ALU_SUB;
          PCSrc      = PCSRC_BRANCH;
          BranchEQ   = (opcode == OP_BEQ);
          BranchNE   = (opcode == OP_BNE);
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSrc    = (opcode == OP_RTYPE) ? PCSRC_REG : PCSRC_JUMP;
          RegWrite = (opcode == OP_JAL);
          WriteRA  = (opcode == OP_JAL);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_control_hs.sv
// Self-checking bench for mc_control_hs: directed scenarios plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_mc_control_hs;
  import mc_ctrl_pkg::*;

  localparam int TMO = 16;
  localparam int CW  = 4;

  localparam logic [5:0] OPS [14] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
  localparam logic [5:0] FNS [14] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22,
                                      6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

  logic clk = 1'b0;
  logic rst, clk_en, stall, mem_ready;
  logic [5:0] opcode, funct;
  logic mem_req, PCWrite, IRWrite, RegWrite, MemWrite, IorD, ALUSrcA, MemToReg, RegDst;
  logic [1:0] PCSrc, ALUSrcB;
  logic [3:0] ALUControl;
  logic ExtOp, UseShamt, WriteRA, BranchEQ, BranchNE, mem_err;
  logic [CW-1:0] instr_count;
  logic [3:0] state_dbg;
`ifdef ILLEGAL_TRAP_EN
  logic trap;
`endif
  logic [21:0] outs;

  int checks = 0;
  int failures = 0;
  int model_count = 0;
  int irw_seen, req_seen, mw_seen;
  bit rand_stall = 1'b0;

  always #5 clk = ~clk;

  assign outs = {mem_req, PCWrite, IRWrite, RegWrite, MemWrite, IorD, ALUSrcA, MemToReg, RegDst,
                 PCSrc, ALUSrcB, ALUControl, ExtOp, UseShamt, WriteRA, BranchEQ, BranchNE};

  mc_control_hs #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .stall(stall), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .MemToReg(MemToReg), .RegDst(RegDst), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ExtOp(ExtOp), .UseShamt(UseShamt), .WriteRA(WriteRA),
    .BranchEQ(BranchEQ), .BranchNE(BranchNE), .mem_err(mem_err), .instr_count(instr_count),
    .state_dbg(state_dbg)
`ifdef ILLEGAL_TRAP_EN
    , .trap(trap)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit r_legal(input logic [5:0] fn);
    return fn inside {6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                      6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  endfunction

  function automatic logic [3:0] exp_alu(input logic [5:0] opc, input logic [5:0] fn);
    logic [3:0] a;
    a = ALU_ADD;
    if (opc == 6'h00) begin
      case (fn)
        6'h00: a = ALU_SLL;
        6'h02: a = ALU_SRL;
        6'h03: a = ALU_SRA;
        6'h22, 6'h23: a = ALU_SUB;
        6'h24: a = ALU_AND;
        6'h25: a = ALU_OR;
        6'h26: a = ALU_XOR;
        6'h27: a = ALU_NOR;
        6'h2A: a = ALU_SLT;
        6'h2B: a = ALU_SLTU;
        default: a = ALU_ADD;
      endcase
    end else begin
      case (opc)
        6'h0A: a = ALU_SLT;
        6'h0C: a = ALU_AND;
        6'h0D: a = ALU_OR;
        6'h0E: a = ALU_XOR;
        default: a = ALU_ADD;
      endcase
    end
    return a;
  endfunction

  // Expected control word for one cycle, from the per-phase rules of the controller.
  function automatic logic [21:0] exp_outs(input state_t st, input logic [5:0] opc,
                                           input logic [5:0] fn, input logic rdy, input logic adv);
    logic req, pcw, irw, rw, mw, iord, sa, m2r, rd, ext, sh, ra, beq, bne;
    logic [1:0] pcs, sb;
    logic [3:0] alu;
    {req, pcw, irw, rw, mw, iord, sa, m2r, rd, sh, ra, beq, bne} = '0;
    pcs = 2'b00; sb = 2'b00; alu = ALU_ADD; ext = 1'b1;
    case (st)
      FETCH:  begin req = 1'b1; sb = 2'b01; irw = rdy & adv; pcw = rdy & adv; end
      DECODE: sb = 2'b11;
      ADDR:   begin sa = 1'b1; sb = 2'b10; end
      MEMRD:  begin req = 1'b1; iord = 1'b1; end
      MEMWR:  begin req = 1'b1; iord = 1'b1; mw = 1'b1; end
      EXEC:   begin sa = 1'b1; alu = exp_alu(opc, fn); sh = fn inside {6'h00, 6'h02, 6'h03}; end
      ALUWB:  begin rw = 1'b1; rd = 1'b1; end
      EXI:    begin sa = 1'b1; sb = 2'b10; alu = exp_alu(opc, fn); ext = !(opc inside {6'h0C, 6'h0D, 6'h0E}); end
      WBI:    begin rw = 1'b1; m2r = (opc == 6'h23); end
      BRANCH: begin sa = 1'b1; alu = ALU_SUB; pcs = 2'b01; beq = (opc == 6'h04); bne = (opc == 6'h05); end
      JUMP:   begin pcw = 1'b1; pcs = (opc == 6'h00) ? 2'b11 : 2'b10; rw = (opc == 6'h03); ra = (opc == 6'h03); end
      default: ;
    endcase
    return {req, pcw, irw, rw, mw, iord, sa, m2r, rd, pcs, sb, alu, ext, sh, ra, beq, bne};
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cycle(input state_t st, input logic rdy, input logic stl, input logic en);
    mem_ready = rdy; stall = stl; clk_en = en;
    #2;
    chk($sformatf("state@%s", st.name()), 32'(state_dbg), 32'(st));
    chk($sformatf("outs@%s", st.name()), 32'(outs), 32'(exp_outs(st, opcode, funct, rdy, en & ~stl)));
    if (IRWrite) irw_seen++;
    if (mem_req) req_seen++;
    if (MemWrite) mw_seen++;
    @(posedge clk); #1;
  endtask

  task automatic adv_step(input state_t st, input logic rdy);
    int n;
    n = 0;
    if (rand_stall && $urandom_range(0, 3) == 0) n = $urandom_range(1, 2);
    for (int i = 0; i < n; i++) begin
      if (rnd1()) cycle(st, rnd1(), 1'b1, 1'b1);
      else        cycle(st, rnd1(), 1'b0, 1'b0);
    end
    cycle(st, rdy, 1'b0, 1'b1);
  endtask

  task automatic mem_phase(input state_t st, input int waits);
    for (int i = 0; i < waits; i++) adv_step(st, 1'b0);
    adv_step(st, 1'b1);
  endtask

  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int wf, input int wd);
    opcode = opc; funct = fn;
    mem_phase(FETCH, wf);
    adv_step(DECODE, rnd1());
    if (opc == 6'h00 && fn == 6'h08) adv_step(JUMP, rnd1());
    else if (opc == 6'h00 && r_legal(fn)) begin adv_step(EXEC, rnd1()); adv_step(ALUWB, rnd1()); end
    else if (opc inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E}) begin adv_step(EXI, rnd1()); adv_step(WBI, rnd1()); end
    else if (opc == 6'h23) begin
      adv_step(ADDR, rnd1()); mem_phase(MEMRD, wd); adv_step(MEMWB, rnd1()); adv_step(WBI, rnd1());
    end
    else if (opc == 6'h2B) begin adv_step(ADDR, rnd1()); mem_phase(MEMWR, wd); end
    else if (opc inside {6'h04, 6'h05}) adv_step(BRANCH, rnd1());
    else if (opc inside {6'h02, 6'h03}) adv_step(JUMP, rnd1());
    model_count = (model_count + 1) % (1 << CW);
    chk($sformatf("instr_count op=%0h fn=%0h", opc, fn), 32'(instr_count), 32'(model_count));
  endtask

  initial begin
    logic [21:0] idle;
    logic [5:0] ro, rf;
    idle = {9'b0, 2'b00, 2'b00, ALU_ADD, 1'b1, 4'b0};
    rst = 1'b1; clk_en = 1'b1; stall = 1'b0; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_state", 32'(state_dbg), 32'(FETCH));
    chk("rst_outs", 32'(outs), 32'(idle));
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
`ifdef ILLEGAL_TRAP_EN
    chk("rst_trap", 32'(trap), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD r3,r1,r2 with zero-wait memory
    run_instr(6'h00, 6'h20, 0, 0);

    // LW with three wait cycles on both fetch and data
    irw_seen = 0; req_seen = 0;
    run_instr(6'h23, 6'h00, 3, 3);
    chk("lw_irwrite_once", 32'(irw_seen), 32'd1);
    chk("lw_req_cycles", 32'(req_seen), 32'd8);

    // Stall with mem_ready pending in MEMRD: watchdog must not advance
    opcode = 6'h23; funct = 6'h00;
    mem_phase(FETCH, 0);
    adv_step(DECODE, 1'b0);
    adv_step(ADDR, 1'b0);
    for (int i = 0; i < 10; i++) cycle(MEMRD, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)  cycle(MEMRD, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)  cycle(MEMRD, 1'b0, 1'b0, 1'b1);
    cycle(MEMRD, 1'b1, 1'b0, 1'b1);
    adv_step(MEMWB, 1'b0);
    adv_step(WBI, 1'b0);
    model_count = (model_count + 1) % (1 << CW);
    chk("stall_count", 32'(instr_count), 32'(model_count));
    chk("stall_no_err", 32'(mem_err), 32'd0);

    // SW with mem_ready held low: times out after MEM_TIMEOUT cycles
    opcode = 6'h2B; funct = 6'h00;
    mem_phase(FETCH, 0);
    adv_step(DECODE, 1'b0);
    adv_step(ADDR, 1'b0);
    mw_seen = 0;
    for (int i = 0; i < TMO; i++) cycle(MEMWR, 1'b0, 1'b0, 1'b1);
    chk("sw_memwrite_cycles", 32'(mw_seen), 32'(TMO));
    chk("sw_timeout_err", 32'(mem_err), 32'd1);
    chk("sw_timeout_state", 32'(state_dbg), 32'(FETCH));
    chk("sw_timeout_count", 32'(instr_count), 32'(model_count));

    // Randomized instruction stream with random waits, stalls and clock-enable gaps
    rand_stall = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ro = OPS[$urandom_range(0, 13)];
      rf = (ro == 6'h00) ? FNS[$urandom_range(0, 13)] : 6'($urandom_range(0, 63));
      run_instr(ro, rf, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    rand_stall = 1'b0;
    chk("err_sticky", 32'(mem_err), 32'd1);

    // Asynchronous reset in the middle of a fetch request
    opcode = 6'h08;
    cycle(FETCH, 1'b0, 1'b0, 1'b1);
    mem_ready = 1'b0;
    #2; rst = 1'b1; #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_state", 32'(state_dbg), 32'(FETCH));
    chk("async_rst_count", 32'(instr_count), 32'd0);
    chk("async_rst_err", 32'(mem_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_count = 0;
    @(posedge clk); #1;

    // Sixteen ADDIs wrap the 4-bit counter 15 -> 0
    for (int n = 0; n < 16; n++) run_instr(6'h08, 6'($urandom_range(0, 63)), 0, 0);
    chk("wrap_zero", 32'(instr_count), 32'd0);

    // Unknown opcode 6'h3F
`ifdef ILLEGAL_TRAP_EN
    opcode = 6'h3F; funct = 6'h00;
    mem_phase(FETCH, 0);
    adv_step(DECODE, 1'b0);
    for (int i = 0; i < 4; i++) cycle(HALT, rnd1(), 1'b0, 1'b1);
    chk("halt_trap", 32'(trap), 32'd1);
    chk("halt_count", 32'(instr_count), 32'(model_count));
`else
    run_instr(6'h3F, 6'h00, 0, 0);
    chk("nop_state", 32'(state_dbg), 32'(FETCH));
    run_instr(6'h00, 6'h01, 1, 0);
    chk("nop_rfunct_state", 32'(state_dbg), 32'(FETCH));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
